// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and helpers for the audio byte/sample path.
//   MAX_BYTES_PER_SAMPLE - widest PCM sample supported by the assemblers
//   MAX_CH               - most interleaved channels per frame
//   ch_w()               - index width for a counter with n states (never 0)
package audio_pkg;

    localparam int MAX_BYTES_PER_SAMPLE = 4;
    localparam int MAX_CH               = 8;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sample_assembler_if.sv
// sample_assembler_if: valid/ready sample stream out of the assembler.
//   out_valid - head sample present        (master -> slave)
//   out_ready - consumer takes the head    (slave -> master)
//   sample    - head sample, SAMPLE_W bits (master -> slave)
//   ch_idx    - channel of the head sample (master -> slave)
interface sample_assembler_if #(
    parameter int SAMPLE_W = 16,
    parameter int CH_W     = 1
);
    logic                out_valid;
    logic                out_ready;
    logic [SAMPLE_W-1:0] sample;
    logic [CH_W-1:0]     ch_idx;

    modport master (output out_valid, output sample, output ch_idx, input out_ready);
    modport slave  (input out_valid, input sample, input ch_idx, output out_ready);
endinterface

// File: rtl/sample_fifo.sv
// sample_fifo: two-entry FIFO holding {ch_idx, sample} words.
//   clk, rst  - clock, synchronous active-high reset
//   push, din - write request and data; ignored when full unless popping
//   pop       - read request; ignored when empty
//   dout      - head entry (zero after reset)
//   full      - both entries occupied
//   empty     - no entries
module sample_fifo #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_pop;
    logic         do_push;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/sample_assembler.sv
// sample_assembler: packs a byte stream into PCM samples tagged with their
// interleaved channel index and offers them through a 2-entry buffer.
//   clk, rst    - clock, synchronous active-high reset
//   validar_in  - byte strobe; D is taken on every asserted cycle
//   D           - input byte
//   sync_in     - with validar_in: this byte is byte 0 of channel 0
//   clr_err     - clears overflow and frame_err (a same-cycle set wins)
//   out_if      - valid/ready sample stream (master side)
//   overflow    - sticky: a completed sample was dropped on a full buffer
//   frame_err   - sticky: sync arrived while a sample/frame was partial
module sample_assembler
    import audio_pkg::*;
#(
    parameter int BYTES_PER_SAMPLE = 2,
    parameter int NUM_CH           = 2,
    parameter int BIG_ENDIAN       = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                validar_in,
    input  logic [7:0]          D,
    input  logic                sync_in,
    input  logic                clr_err,
    sample_assembler_if.master  out_if,
    output logic                overflow,
    output logic                frame_err
);
    localparam int SAMPLE_W = 8 * BYTES_PER_SAMPLE;
    localparam int CH_W     = ch_w(NUM_CH);
    localparam int BW       = ch_w(BYTES_PER_SAMPLE);
    localparam logic [BW-1:0]   B_LAST = BW'(BYTES_PER_SAMPLE - 1);
    localparam logic [CH_W-1:0] C_LAST = CH_W'(NUM_CH - 1);

    logic [BW-1:0]          bcnt;
    logic [CH_W-1:0]        ccnt;
    logic [SAMPLE_W-1:0]    lanes;
    logic [BW-1:0]          eff_b;
    logic [CH_W-1:0]        eff_c;
    logic [SAMPLE_W-1:0]    word;
    logic                   sync_v;
    logic                   complete;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   drop;
    int                     lane;

    assign sync_v = validar_in && sync_in;

    // A sync byte restarts the frame: the counters behave as if already at 0
    // and any partially collected lanes are thrown away.
    always_comb begin
        eff_b = sync_v ? '0 : bcnt;
        eff_c = sync_v ? '0 : ccnt;
        lane  = (BIG_ENDIAN != 0) ? (BYTES_PER_SAMPLE - 1 - int'(eff_b)) : int'(eff_b);
        word  = sync_v ? '0 : lanes;
        word[lane*8 +: 8] = D;
        complete = validar_in && (eff_b == B_LAST);
    end

    assign pop  = out_if.out_valid && out_if.out_ready;
    assign drop = complete && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt      <= '0;
            ccnt      <= '0;
            lanes     <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (validar_in) begin
                lanes <= word;
                if (complete) begin
                    bcnt <= '0;
                    ccnt <= (eff_c == C_LAST) ? '0 : eff_c + CH_W'(1);
                end else begin
                    bcnt <= eff_b + BW'(1);
                    ccnt <= eff_c;
                end
            end

            if (sync_v && (bcnt != '0 || ccnt != '0)) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
        end
    end

    sample_fifo #(
        .W(CH_W + SAMPLE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (complete),
        .pop   (pop),
        .din   ({eff_c, word}),
        .dout  ({out_if.ch_idx, out_if.sample}),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_if.out_valid = !fifo_empty;
endmodule

// File: tb/tb_sample_assembler.sv
// tb_sample_assembler: drives two assembler configurations with one shared
// byte stream and checks both against a queue-based reference model.
//   dut0: 2 bytes/sample, 2 channels, little endian
//   dut1: 3 bytes/sample, 1 channel, big endian
module tb_sample_assembler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       validar_in = 1'b0;
    logic [7:0] D = 8'h00;
    logic       sync_in = 1'b0;
    logic       clr_err = 1'b0;
    logic       out_ready = 1'b0;
    logic       ovf0, fe0, ovf1, fe1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sample_assembler_if #(.SAMPLE_W(16), .CH_W(1)) if0 ();
    sample_assembler_if #(.SAMPLE_W(24), .CH_W(1)) if1 ();
    assign if0.out_ready = out_ready;
    assign if1.out_ready = out_ready;

    sample_assembler #(.BYTES_PER_SAMPLE(2), .NUM_CH(2), .BIG_ENDIAN(0)) dut0 (
        .clk(clk), .rst(rst), .validar_in(validar_in), .D(D), .sync_in(sync_in),
        .clr_err(clr_err), .out_if(if0), .overflow(ovf0), .frame_err(fe0));

    sample_assembler #(.BYTES_PER_SAMPLE(3), .NUM_CH(1), .BIG_ENDIAN(1)) dut1 (
        .clk(clk), .rst(rst), .validar_in(validar_in), .D(D), .sync_in(sync_in),
        .clr_err(clr_err), .out_if(if1), .overflow(ovf1), .frame_err(fe1));

    // Reference model: bytes collected per sample, a list of buffered samples.
    int          cfg_bps [2] = '{2, 3};
    int          cfg_nch [2] = '{2, 1};
    int          cfg_be  [2] = '{0, 1};
    int          nb      [2];
    int          chn     [2];
    logic [7:0]  byt     [2][4];
    logic [31:0] fq_s    [2][2];
    int          fq_c    [2][2];
    int          fq_n    [2];
    bit          m_ovf   [2];
    bit          m_fe    [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            nb[i] = 0; chn[i] = 0; fq_n[i] = 0; m_ovf[i] = 0; m_fe[i] = 0;
        end
    endtask

    task automatic model_step(input int id, input logic v, input logic [7:0] d,
                              input logic s, input logic c, input logic r);
        bit          pop, push, fe_set, ov_set;
        logic [31:0] val;
        int          pch;
        pop = 0; push = 0; fe_set = 0; ov_set = 0; val = 0; pch = 0;
        pop = (fq_n[id] > 0) && r;
        if (v) begin
            if (s) begin
                fe_set  = (nb[id] != 0) || (chn[id] != 0);
                nb[id]  = 0;
                chn[id] = 0;
            end
            byt[id][nb[id]] = d;
            nb[id]++;
            if (nb[id] == cfg_bps[id]) begin
                for (int i = 0; i < cfg_bps[id]; i++) begin
                    if (cfg_be[id] != 0) val = (val << 8) | 32'(byt[id][i]);
                    else                 val = val | (32'(byt[id][i]) << (8 * i));
                end
                push    = 1;
                pch     = chn[id];
                nb[id]  = 0;
                chn[id] = (chn[id] + 1) % cfg_nch[id];
            end
        end
        if (pop) begin
            fq_s[id][0] = fq_s[id][1];
            fq_c[id][0] = fq_c[id][1];
            fq_n[id]--;
        end
        if (push) begin
            if (fq_n[id] < 2) begin
                fq_s[id][fq_n[id]] = val;
                fq_c[id][fq_n[id]] = pch;
                fq_n[id]++;
            end else begin
                ov_set = 1;
            end
        end
        if (ov_set)   m_ovf[id] = 1;
        else if (c)   m_ovf[id] = 0;
        if (fe_set)   m_fe[id]  = 1;
        else if (c)   m_fe[id]  = 0;
    endtask

    task automatic compare(input int id);
        logic        v, o, f;
        logic [31:0] s, c;
        if (id == 0) begin
            v = if0.out_valid; s = 32'(if0.sample); c = 32'(if0.ch_idx); o = ovf0; f = fe0;
        end else begin
            v = if1.out_valid; s = 32'(if1.sample); c = 32'(if1.ch_idx); o = ovf1; f = fe1;
        end
        chk($sformatf("d%0d_valid", id), 32'(v), 32'(fq_n[id] > 0));
        if (fq_n[id] > 0) begin
            chk($sformatf("d%0d_sample", id), s, fq_s[id][0]);
            chk($sformatf("d%0d_ch", id), c, 32'(fq_c[id][0]));
        end
        chk($sformatf("d%0d_ovf", id), 32'(o), 32'(m_ovf[id]));
        chk($sformatf("d%0d_ferr", id), 32'(f), 32'(m_fe[id]));
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic s,
                       input logic c, input logic r);
        validar_in = v; D = d; sync_in = s; clr_err = c; out_ready = r;
        model_step(0, v, d, s, c, r);
        model_step(1, v, d, s, c, r);
        @(posedge clk);
        #1;
        compare(0);
        compare(1);
    endtask

    task automatic do_reset();
        rst = 1'b1; validar_in = 1'b0; sync_in = 1'b0; clr_err = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_valid0", 32'(if0.out_valid), 0);
        chk("rst_sample0", 32'(if0.sample), 0);
        chk("rst_ch0", 32'(if0.ch_idx), 0);
        chk("rst_flags0", {30'd0, ovf0, fe0}, 0);
        chk("rst_valid1", 32'(if1.out_valid), 0);
        chk("rst_sample1", 32'(if1.sample), 0);
        chk("rst_flags1", {30'd0, ovf1, fe1}, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Little-endian pairs, two channels.
        cyc(1, 8'h34, 0, 0, 1);
        cyc(1, 8'h12, 0, 0, 1);
        chk("tp1_s0", 32'(if0.sample), 32'h1234);
        chk("tp1_c0", 32'(if0.ch_idx), 0);
        cyc(1, 8'h78, 0, 0, 1);
        chk("tp1_gap", 32'(if0.out_valid), 0);
        cyc(1, 8'h56, 0, 0, 1);
        chk("tp1_s1", 32'(if0.sample), 32'h5678);
        chk("tp1_c1", 32'(if0.ch_idx), 1);

        // Big-endian 3-byte samples, single channel.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            cyc(1, 8'hAA, 0, 0, 1);
            cyc(1, 8'hBB, 0, 0, 1);
            cyc(1, 8'hCC, 0, 0, 1);
            chk("tp2_s", 32'(if1.sample), 32'hAABBCC);
            chk("tp2_c", 32'(if1.ch_idx), 0);
            chk("tp2_v", 32'(if1.out_valid), 1);
        end

        // Overflow: three samples into a stalled buffer.
        do_reset();
        for (int k = 1; k <= 6; k++) cyc(1, 8'(k), 0, 0, 0);
        chk("tp3_head", 32'(if0.sample), 32'h0201);
        chk("tp3_ovf", 32'(ovf0), 1);
        cyc(0, 8'h00, 0, 0, 1);
        chk("tp3_second", 32'(if0.sample), 32'h0403);
        cyc(0, 8'h00, 0, 0, 1);
        chk("tp3_empty", 32'(if0.out_valid), 0);
        cyc(0, 8'h00, 0, 1, 0);
        chk("tp3_clr", 32'(ovf0), 0);

        // Sync in the middle of a sample.
        do_reset();
        cyc(1, 8'h11, 0, 0, 1);
        cyc(1, 8'h22, 1, 0, 1);
        chk("tp4_ferr", 32'(fe0), 1);
        chk("tp4_nopush", 32'(if0.out_valid), 0);
        cyc(1, 8'h33, 0, 0, 1);
        chk("tp4_s", 32'(if0.sample), 32'h3322);
        chk("tp4_c", 32'(if0.ch_idx), 0);

        // Push and pop together on a full buffer.
        do_reset();
        for (int k = 1; k <= 5; k++) cyc(1, 8'(k), 0, 0, 0);
        cyc(1, 8'h06, 0, 0, 1);
        chk("tp5_ovf", 32'(ovf0), 0);
        chk("tp5_head", 32'(if0.sample), 32'h0403);
        cyc(0, 8'h00, 0, 0, 1);
        chk("tp5_next", 32'(if0.sample), 32'h0605);

        // Reset in the middle of a sample.
        do_reset();
        cyc(1, 8'h99, 0, 0, 1);
        do_reset();
        cyc(1, 8'h01, 0, 0, 1);
        cyc(1, 8'h02, 0, 0, 1);
        chk("tp6_s", 32'(if0.sample), 32'h0201);
        chk("tp6_c", 32'(if0.ch_idx), 0);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                8'($urandom),
                ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sample_assembler.md
# sample_assembler

Parametrised byte-to-sample assembler for the audio data path. It collects a byte stream (`validar_in`/`D`) into multi-byte PCM samples and tags each sample with its channel index for interleaved multi-channel audio. Completed samples are presented on a valid/ready output through a 2-entry buffer. Frame resynchronisation, drop-on-overflow and error flags are included. It sits between the byte receiver and the sample memory/I2S transmit path.

## Interface
- `BYTES_PER_SAMPLE`, 2, bytes per sample (1..4); `SAMPLE_W = 8*BYTES_PER_SAMPLE`
- `NUM_CH`, 2, interleaved channels per frame (1..8); `CH_W = max(1, $clog2(NUM_CH))`
- `BIG_ENDIAN`, 0, 0: first byte → bits [7:0]; 1: first byte → MSB byte
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `validar_in`  in  1  byte strobe, one byte per asserted cycle, no backpressure
- `D`  in  8  input byte, sampled when `validar_in`=1
- `sync_in`  in  1  qualified by `validar_in`: the current byte is byte 0 of channel 0
- `clr_err`  in  1  clears the sticky flags
- `out_valid`  out  1  buffer head holds a sample
- `out_ready`  in  1  consumer accepts the head when `out_valid`&`out_ready`
- `sample`  out  SAMPLE_W  head sample
- `ch_idx`  out  CH_W  channel of the head sample
- `overflow`  out  1  sticky: a completed sample was dropped (buffer full)
- `frame_err`  out  1  sticky: `sync_in` arrived with a partial sample/frame pending

## Operation
- Byte counter `bcnt` runs 0..BYTES_PER_SAMPLE-1. Channel counter `ccnt` runs 0..NUM_CH-1. Each accepted byte is written into the byte lane selected by `bcnt` and `BIG_ENDIAN`.
- When the byte with `bcnt`=BYTES_PER_SAMPLE-1 is accepted, the assembled word (lanes plus this byte) and `ccnt` are pushed. Then `bcnt`→0, and `ccnt` increments, wrapping NUM_CH-1→0.
- `sync_in`&`validar_in`: the byte is stored as lane 0 of channel 0 (`bcnt`=1 next, `ccnt`=0). Any partial lanes are discarded.
  - `frame_err` sets if `bcnt`≠0 or `ccnt`≠0 beforehand.
  - A sync at an exact frame boundary is silent.
  - With BYTES_PER_SAMPLE=1, a sync byte completes and pushes immediately with `ch_idx`=0.
- Output buffer: 2-entry FIFO.
  - A push while full and not popping in the same cycle drops the new sample and sets `overflow`. Buffer contents are unchanged.
  - A push and pop in the same cycle while full is accepted, with no overflow.
- `clr_err` clears both flags. If a set event occurs in the same cycle, the set wins.
- `validar_in`=0: no state change in the counters or lanes.
- Reset values:
  - `out_valid`=0, `sample`=0, `ch_idx`=0, `overflow`=0, `frame_err`=0
  - `bcnt`=0, `ccnt`=0, lanes=0, FIFO empty
- Reset mid-sample discards the partial sample and the buffered samples.

## Timing
- Latency: the final byte accepted at edge N gives `out_valid`=1 with the new sample after edge N, provided the buffer was empty.
- Handshake:
  - `sample`/`ch_idx` stay stable while `out_valid`&!`out_ready`.
  - Pop takes effect at the edge where `out_valid`&`out_ready`.
  - `out_valid` is not combinationally dependent on `out_ready`.
- Sustained throughput is one sample per BYTES_PER_SAMPLE strobes. Back-to-back strobes every cycle are legal.
- Flags update at the edge of the causing byte and are visible the next cycle.

## Structure
- Shared package `audio_pkg`: `MAX_BYTES_PER_SAMPLE`=4, `MAX_CH`=8, and the `CH_W` helper function.
- Sub-module `sample_fifo` (parametrised width, depth 2, push/pop/full/empty). It holds {`ch_idx`,`sample`}. The assembler core holds the counters, lanes and flags.

## Test plan
- Defaults, `out_ready`=1, bytes 0x34,0x12,0x78,0x56 on consecutive cycles → samples 0x1234 ch0, then 0x5678 ch1, each one cycle after its last byte.
- BIG_ENDIAN=1, BYTES_PER_SAMPLE=3, NUM_CH=1, bytes 0xAA,0xBB,0xCC → 0xAABBCC, `ch_idx`=0. Repeat the sequence → `ch_idx` stays 0 (wrap at NUM_CH=1).
- `out_ready`=0, push three samples → first two held in order, third dropped, `overflow`=1. Raise `out_ready` → 2 samples drain. `clr_err` → `overflow`=0.
- Bytes 0x11, then 0x22 with `sync_in` → `frame_err`=1, no push. Then 0x33 → sample 0x3322 ch0.
- FIFO full, `out_ready`=1, final byte in the same cycle → pop and push both happen, `overflow` stays 0, order preserved.
- `rst` asserted after one byte of a sample → all outputs 0. Next bytes 0x01,0x02 → 0x0201 ch0.
